uart_tx: RTL and testbench
==========================

# uart_tx

- UART transmitter: the transmit-side counterpart of the team's UART receiver, using the same baud derivation.
- Serializes a byte from a valid/ready parallel interface into an 8-bit, LSB-first frame: one start bit, optional parity, 1 or 2 stop bits.
- A one-entry holding register lets the next byte be accepted mid-frame, so frames can be sent back-to-back with no idle gap.
- Sits between the system-side byte producer and the serial `tx` pin.

## Interface

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate. BAUD_TICK_COUNT = CLK_FREQ / BAUD_RATE (integer divide) cycles per bit. Legal range is 2..65536.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to transmit; sampled on the accept edge.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  holding register empty, so a byte can be accepted.
- tx  output  1  serial line, idle high; registered.
- tx_busy  output  1  a frame is on the line (START through the final STOP).
- tx_done  output  1  one-cycle pulse at the end of each frame.

## Operation

- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, holding register empty, counters 0.
- Accept: a byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is copied to the holding register and hold_full is set.
  - tx_ready = !hold_full, combinational from the flag.
- While tx_ready=0, tx_valid and tx_data are ignored; the producer holds them.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If hold_full, move the holding register into the shift register, clear hold_full, go to START with tx=0.
  - START: one bit period with tx=0, then DATA, bit_index=0.
  - DATA: drive shift[0] for one bit period, then shift right. After bit_index 7, go to PARITY if PARITY!=0, else STOP.
  - PARITY: even drives ^byte; odd drives ~^byte. Lasts one bit period.
  - STOP: tx=1 for STOP_BITS bit periods.
- End of the final stop period:
  - tx_done pulses for one cycle.
  - If hold_full, go directly to START (the load happens on the same edge). There is no IDLE cycle and no line gap.
  - Otherwise go to IDLE.
- Every bit period lasts exactly BAUD_TICK_COUNT cycles.
  - 16-bit baud_counter counts 0..BAUD_TICK_COUNT-1, then wraps to 0 and advances the bit.
  - The counter is cleared on entry to START.
- Frame length = BAUD_TICK_COUNT × (10 + (PARITY!=0) + (STOP_BITS-1)) cycles.
- Parity is computed from the byte latched into the shift register, not from live tx_data.
- An accept in the same cycle the holding register is loaded into the shifter cannot occur (tx_ready=0 that cycle). The next accept is possible on the following edge.
- Reset asserted mid-frame:
  - tx goes to 1 immediately (asynchronously).
  - Any held byte is discarded.
  - No tx_done is produced.
- Unsupported parameters: STOP_BITS other than 1/2 or PARITY>2 trigger a simulation-time $error.

## Timing

- Accept edge E0 sets hold_full, and tx_ready falls after E0.
- At E1 (IDLE): tx falls to 0, tx_busy rises, tx_ready returns to 1.
- Accept-to-start latency is 1 cycle.
- The start bit occupies edges E1..E1+BAUD_TICK_COUNT-1. Data bit 0 begins at E1+BAUD_TICK_COUNT.
- tx_done is high for exactly the cycle after the final stop period's last count.
  - tx_busy falls on that same edge if no byte is held.
  - If a byte is held, tx_busy stays high and tx falls on that same edge.
- tx changes only on bit-period boundaries (glitch-free, registered).

## Test plan

All scenarios use CLK_FREQ=16, BAUD_RATE=1, so BAUD_TICK_COUNT=16.

- Reset: rst_n low, then release → tx=1, tx_ready=1, tx_busy=0, tx_done=0. The line stays at 1 for 100 idle cycles.
- Single byte 0xA5, PARITY=0, STOP_BITS=1:
  - Mid-bit samples must read 0,1,0,1,0,0,1,0,1,1.
  - tx falls 1 cycle after accept.
  - tx_done pulses once, 160 cycles after tx falls.
- Back-to-back 0x00 then 0xFF, second byte offered while the first frame is in DATA:
  - The second byte is accepted mid-frame.
  - The second start bit begins on the edge the first stop bit ends, with zero idle cycles.
  - tx_done pulses twice, 160 cycles apart.
- Parity and stop-bit variants:
  - PARITY=1 with 0x07 → parity bit 1.
  - PARITY=2 with 0x07 → parity bit 0.
  - STOP_BITS=2 → frame of 12×16=192 cycles with 32 cycles high at the end.
- Backpressure: tx_valid held with 0x11 then 0x22 while tx_ready=0 → each byte is transmitted exactly once, in order, with no duplicate or lost byte.
- Reset mid-frame: rst_n low during DATA bit 3 → tx=1 at once and no tx_done. After release, a new byte 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter. Takes bytes from a valid/ready producer interface and
// serializes them onto the tx pin as 8-bit LSB-first frames:
//     START(0) | D0..D7 | [PARITY] | STOP(1) x STOP_BITS
// A one-entry holding register accepts the next byte while a frame is on the
// line, so consecutive frames go out back-to-back with no idle gap. The bit
// period is BAUD_TICK_COUNT = CLK_FREQ / BAUD_RATE system clocks, the same
// derivation the receiver uses.
//
// Parameters:
//     CLK_FREQ   system clock frequency in Hz
//     BAUD_RATE  serial bit rate (BAUD_TICK_COUNT must be 2..65536)
//     PARITY     0 = none, 1 = even, 2 = odd
//     STOP_BITS  1 or 2
//
// Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     tx_data   in   [7:0] byte to send, sampled on the accept edge
//     tx_valid  in   producer has a byte
//     tx_ready  out  holding register empty (combinational from its flag)
//     tx        out  serial line, idle high, registered
//     tx_busy   out  a frame is on the line (START through final STOP)
//     tx_done   out  one-cycle pulse after the final stop period
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int          BAUD_TICK_COUNT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] BAUD_LAST       = 16'(BAUD_TICK_COUNT - 1);
    localparam logic        STOP_LAST       = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic        PARITY_EN       = (PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic        PARITY_ODD      = (PARITY == 2) ? 1'b1 : 1'b0;

    // Reject configurations the frame logic does not implement.
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if ((BAUD_TICK_COUNT < 2) || (BAUD_TICK_COUNT > 65536)) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be in 2..65536");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  hold_r;
    logic        hold_full_r;
    logic [7:0]  shift_r;
    logic        parity_r;
    logic [15:0] baud_cnt_r;
    logic [2:0]  bit_idx_r;
    logic        stop_idx_r;

    logic        accept_s;
    logic        bit_end_s;
    logic        frame_end_s;
    logic        load_s;

    // Parity of a byte; odd=1 inverts the even-parity result.
    function automatic logic parity_calc(input logic [7:0] data, input logic odd);
        parity_calc = (^data) ^ odd;
    endfunction

    assign tx_ready    = ~hold_full_r;
    assign accept_s    = tx_valid & ~hold_full_r;
    assign bit_end_s   = (baud_cnt_r == BAUD_LAST);
    assign frame_end_s = (state_r == ST_STOP) & bit_end_s & (stop_idx_r == STOP_LAST);
    // A held byte enters the shifter from IDLE, or directly at the end of the
    // final stop period so the next start bit follows with no idle cycle.
    // Accept and load are exclusive: accept needs the holder empty, load full.
    assign load_s      = hold_full_r & ((state_r == ST_IDLE) | frame_end_s);

    // Frame sequencer, holding register, baud counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            shift_r     <= 8'h00;
            parity_r    <= 1'b0;
            baud_cnt_r  <= 16'd0;
            bit_idx_r   <= 3'd0;
            stop_idx_r  <= 1'b0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= frame_end_s;

            if (accept_s) begin
                hold_r      <= tx_data;
                hold_full_r <= 1'b1;
            end else begin
                hold_r      <= hold_r;
            end

            case (state_r)
                ST_IDLE: begin
                    tx         <= 1'b1;
                    tx_busy    <= 1'b0;
                    baud_cnt_r <= 16'd0;
                end

                ST_START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        state_r    <= ST_DATA;
                        tx         <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            if (PARITY_EN) begin
                                state_r <= ST_PARITY;
                                tx      <= parity_r;
                            end else begin
                                state_r    <= ST_STOP;
                                stop_idx_r <= 1'b0;
                                tx         <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            // Next bit is shift_r[1] before the shift lands.
                            tx        <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end

                ST_PARITY: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        state_r    <= ST_STOP;
                        stop_idx_r <= 1'b0;
                        tx         <= 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end

                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (stop_idx_r == STOP_LAST) begin
                            state_r <= ST_IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end else begin
                            stop_idx_r <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= 16'd0;
                    tx         <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase

            // Load overrides whatever the state case chose on this edge.
            // Parity is taken from the byte being latched, not live tx_data.
            if (load_s) begin
                shift_r     <= hold_r;
                parity_r    <= parity_calc(hold_r, PARITY_ODD);
                hold_full_r <= 1'b0;
                state_r     <= ST_START;
                baud_cnt_r  <= 16'd0;
                tx          <= 1'b0;
                tx_busy     <= 1'b1;
            end else begin
                parity_r    <= parity_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Bench for uart_tx with BAUD_TICK_COUNT = 16. Four instances cover the
// frame variants: u0 no parity/1 stop, u1 even/1 stop, u2 odd/1 stop,
// u3 odd/2 stops. A frame-level model (frame position counter plus holding
// register flag) predicts tx/tx_busy/tx_done/tx_ready for every instance and
// is compared each falling clock edge. Directed scenarios add hand-computed
// literal expectations, and a serial receiver on u0 collects decoded bytes.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int PAR_CFG [4] = '{0, 1, 2, 2};
    localparam int STP_CFG [4] = '{1, 1, 1, 2};
    localparam int NTICK       = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] valid_a = 4'b0000;
    logic [7:0] data_a [4];
    logic [3:0] ready_s;
    logic [3:0] tx_s;
    logic [3:0] busy_s;
    logic [3:0] done_s;

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx #(
            .CLK_FREQ (16),
            .BAUD_RATE(1),
            .PARITY   (PAR_CFG[g]),
            .STOP_BITS(STP_CFG[g])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .tx_data (data_a[g]),
            .tx_valid(valid_a[g]),
            .tx_ready(ready_s[g]),
            .tx      (tx_s[g]),
            .tx_busy (busy_s[g]),
            .tx_done (done_s[g])
        );
    end

    always #5 clk = ~clk;

    // ---------------- frame-level model ----------------
    bit       m_active    [4];
    int       m_cyc       [4];
    bit [7:0] m_byte      [4];
    bit       m_hold_full [4];
    bit [7:0] m_hold      [4];
    bit       m_done      [4];
    bit       m_acc       [4];

    function automatic int flen(input int k);
        return NTICK * (10 + ((PAR_CFG[k] != 0) ? 1 : 0) + (STP_CFG[k] - 1));
    endfunction

    // Expected line level from the position inside the current frame.
    function automatic logic exp_tx(input int k);
        int bn;
        if (!m_active[k]) return 1'b1;
        bn = m_cyc[k] / NTICK;
        if (bn == 0) return 1'b0;
        if (bn <= 8) return m_byte[k][bn - 1];
        if ((bn == 9) && (PAR_CFG[k] != 0))
            return (PAR_CFG[k] == 1) ? (^m_byte[k]) : ~(^m_byte[k]);
        return 1'b1;
    endfunction

    initial begin : model
        bit pre_full;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 4; k++) begin
                if (!rst_n) begin
                    m_active[k] = 1'b0; m_cyc[k] = 0; m_hold_full[k] = 1'b0;
                    m_done[k] = 1'b0; m_acc[k] = 1'b0;
                end else begin
                    pre_full  = m_hold_full[k];
                    m_done[k] = 1'b0;
                    m_acc[k]  = 1'b0;
                    if (m_active[k]) begin
                        m_cyc[k]++;
                        if (m_cyc[k] == flen(k)) begin
                            m_active[k] = 1'b0;
                            m_done[k]   = 1'b1;
                        end
                    end
                    if (!m_active[k] && pre_full) begin
                        m_active[k] = 1'b1; m_cyc[k] = 0;
                        m_byte[k] = m_hold[k]; m_hold_full[k] = 1'b0;
                    end else if (valid_a[k] && !pre_full) begin
                        m_hold[k] = data_a[k]; m_hold_full[k] = 1'b1; m_acc[k] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input string what, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s vs model: got %b, expected %b (t=%0t)", k, what, act, exp, $time);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                cmp(k, "tx",       tx_s[k],    exp_tx(k));
                cmp(k, "tx_busy",  busy_s[k],  m_active[k]);
                cmp(k, "tx_done",  done_s[k],  m_done[k]);
                cmp(k, "tx_ready", ready_s[k], ~m_hold_full[k]);
            end
        end
    end

    // ---------------- serial receiver on u0 ----------------
    logic [7:0] dec_q [$];
    int         dec_bad = 0;

    initial begin : decoder
        int pos;
        logic [7:0] b;
        pos = -1;
        b   = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pos = -1;
            end else if (pos < 0) begin
                if (tx_s[0] === 1'b0) pos = 0;
            end else begin
                pos++;
                if ((pos % NTICK == 8) && (pos / NTICK >= 1) && (pos / NTICK <= 8))
                    b[pos / NTICK - 1] = tx_s[0];
                if (pos == 9 * NTICK + 8) begin
                    if (tx_s[0] === 1'b1) dec_q.push_back(b);
                    else dec_bad++;
                    pos = -1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a byte and hold it until the interface accepts it.
    task automatic send(input int k, input logic [7:0] b);
        int n;
        data_a[k]  = b;
        valid_a[k] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc[k] && (n < 1000));
        if (!m_acc[k]) check($sformatf("u%0d accept timeout", k), 32'd0, 32'd1);
        valid_a[k] = 1'b0;
    endtask

    task automatic wait_fall(input int k, output int n);
        n = 0;
        while ((tx_s[k] !== 1'b0) && (n < 64)) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(input int k, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((done_s[k] !== 1'b1) && (n < 400));
        if (done_s[k] !== 1'b1) check($sformatf("u%0d done timeout", k), 32'd0, 32'd1);
    endtask

    // Send one byte from idle, check start latency and mid-bit samples,
    // and return frame length (start fall to tx_done) and high tail length.
    task automatic run_frame(input int k, input logic [7:0] b, input int nbits,
                             input logic [11:0] exp_smp, output logic [11:0] smp,
                             output int flen_m, output int tail);
        int n;
        int c;
        int last_low;
        send(k, b);
        wait_fall(k, n);
        check($sformatf("u%0d byte %02h start latency", k, b), n, 1);
        smp = 12'hFFF; c = 0; last_low = 0; flen_m = -1;
        while (c < 400) begin
            tick();
            c++;
            if (done_s[k] === 1'b1) begin
                flen_m = c;
                break;
            end
            if (tx_s[k] === 1'b0) last_low = c;
            if ((c % NTICK == 8) && (c / NTICK < 12)) smp[c / NTICK] = tx_s[k];
        end
        tail = flen_m - 1 - last_low;
        for (int i = 0; i < nbits; i++)
            check($sformatf("u%0d byte %02h mid-bit %0d", k, b, i), smp[i], exp_smp[i]);
    endtask

    // ---------------- directed scenarios ----------------
    logic [7:0] exp_dec [7] = '{8'hA5, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h3C};

    initial begin : main
        int n;
        int fl;
        int tl;
        int cnt;
        logic [11:0] smp;

        for (int k = 0; k < 4; k++) data_a[k] = 8'h00;

        // Reset values
        repeat (3) tick();
        check("reset tx",       tx_s[0],    1'b1);
        check("reset tx_ready", ready_s[0], 1'b1);
        check("reset tx_busy",  busy_s[0],  1'b0);
        check("reset tx_done",  done_s[0],  1'b0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (100) begin
            tick();
            if (tx_s[0] === 1'b1) cnt++;
        end
        check("idle line high cycles", cnt, 100);

        // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1
        run_frame(0, 8'hA5, 10, 12'h34A, smp, fl, tl);
        check("A5 done after start fall", fl, 160);

        // Back-to-back 0x00 then 0xFF, second offered during DATA
        send(0, 8'h00);
        repeat (40) tick();
        send(0, 8'hFF);
        check("b2b second accepted mid-frame busy", busy_s[0], 1'b1);
        wait_done(0, n);
        check("b2b start on first done edge", tx_s[0], 1'b0);
        check("b2b busy stays high",          busy_s[0], 1'b1);
        wait_done(0, n);
        check("b2b done spacing", n, 160);

        // Parity and stop-bit variants
        run_frame(1, 8'h07, 11, 12'h60E, smp, fl, tl);
        check("even parity bit of 07", smp[9], 1'b1);
        check("even parity frame length", fl, 176);
        run_frame(2, 8'h07, 11, 12'h40E, smp, fl, tl);
        check("odd parity bit of 07", smp[9], 1'b0);
        check("odd parity frame length", fl, 176);
        run_frame(3, 8'h07, 12, 12'hC0E, smp, fl, tl);
        check("two-stop frame length", fl, 192);
        check("two-stop high tail", tl, 32);

        // Backpressure: valid held while the holder is full
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        wait_done(0, n);
        wait_done(0, n);
        check("backpressure last frame spacing", n, 160);
        repeat (10) tick();

        // Reset mid-frame during data bit 3 with a byte held
        send(0, 8'h5A);
        wait_fall(0, n);
        send(0, 8'h77);
        repeat (68) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx high",      tx_s[0],    1'b1);
        check("async reset busy low",     busy_s[0],  1'b0);
        check("async reset holder empty", ready_s[0], 1'b1);
        cnt = 0;
        repeat (5) begin
            tick();
            if (done_s[0] === 1'b1) cnt++;
        end
        rst_n = 1'b1;
        repeat (30) begin
            tick();
            if (done_s[0] === 1'b1) cnt++;
        end
        check("no tx_done after mid-frame reset", cnt, 0);
        check("held byte discarded, line idle", tx_s[0], 1'b1);
        run_frame(0, 8'h3C, 10, 12'h278, smp, fl, tl);
        check("3C frame length after reset", fl, 160);
        repeat (5) tick();

        // Everything u0 put on the line, in order, exactly once
        check("decoded byte count", dec_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < dec_q.size()) check($sformatf("decoded byte %0d", i), dec_q[i], exp_dec[i]);
            else check($sformatf("decoded byte %0d missing", i), 32'd0, 32'd1);
        end
        check("decoder framing errors", dec_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
